// File: rtl/pwr_sched_pkg.sv
// Shared types, constants and small helpers for the power vector scheduler.
package pwr_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StReport
    } state_e;

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_GRAY = 2'd1;
    localparam logic [1:0] MODE_LFSR = 2'd2;

    // Feedback taps for x^4 + x^3 + 1: new lsb = v[3] ^ v[2].
    localparam logic [3:0] LFSR_TAPS     = 4'b1100;
    localparam logic [3:0] LFSR_SEED_DEF = 4'b0001;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ {1'b0, b[3:1]};
    endfunction

    function automatic logic [3:0] lfsr_step(input logic [3:0] v);
        return {v[2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/power_cut_eval.sv
// Combinational 4-input power cut: y = (~n_1 & n_4) ^ (n_2 & n_3 & n_4).
// n_i[0]=n_1 .. n_i[3]=n_4. Kept separate so rewritten cuts can be dropped in.
module power_cut_eval (
    input  logic [3:0] n_i,
    output logic       y_o
);

    // Cut function.
    always_comb begin
        y_o = (~n_i[0] & n_i[3]) ^ (n_i[1] & n_i[2] & n_i[3]);
    end

endmodule

// File: rtl/pwr_vec_sched.sv
// Applies one vector per clock to power_cut_eval in binary, Gray or LFSR order and
// accumulates input toggles, output toggles and output ones with saturating counters.
module pwr_vec_sched
    import pwr_sched_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [NUM_IN-1:0] seed_i,
    input  logic [CNT_W-1:0]  num_vec_i,
    output logic              busy_o,
    output logic [NUM_IN-1:0] vec_o,
    output logic              y_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [CNT_W-1:0]  in_toggles_o,
    output logic [CNT_W-1:0]  out_toggles_o,
    output logic [CNT_W-1:0]  ones_o,
    output logic              done_o
);

    state_e              state_q;
    logic [1:0]          mode_q;
    logic [CNT_W-1:0]    num_vec_q;
    logic [CNT_W-1:0]    k_q;
    logic [NUM_IN-1:0]   vec_q;
    logic [NUM_IN-1:0]   prev_vec_q;
    logic                prev_y_q;
    logic [CNT_W-1:0]    in_tog_q;
    logic [CNT_W-1:0]    out_tog_q;
    logic [CNT_W-1:0]    ones_q;
    logic                busy_q;
    logic                res_valid_q;
    logic                done_q;

    logic                y;
    logic [CNT_W-1:0]    k_next;
    logic [NUM_IN-1:0]   vec_next;
    logic [NUM_IN-1:0]   vec_first;
    logic [2:0]          in_inc;
    logic [2:0]          out_inc;
    logic                last_vec;

    power_cut_eval u_cut (
        .n_i (vec_q),
        .y_o (y)
    );

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [2:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Next vector, first vector and per-cycle counter increments.
    always_comb begin
        k_next = k_q + 1'b1;
        case (mode_q)
            MODE_GRAY: vec_next = gray4(k_next[3:0]);
            MODE_LFSR: vec_next = lfsr_step(vec_q);
            default:   vec_next = k_next[3:0];
        endcase
        if (mode_i == MODE_LFSR) begin
            vec_first = (seed_i == '0) ? LFSR_SEED_DEF : seed_i;
        end else begin
            vec_first = '0;
        end
        // The first vector of a run has no predecessor to toggle against.
        in_inc   = (k_q != '0) ? popcount4(vec_q ^ prev_vec_q) : 3'd0;
        out_inc  = {2'b00, (k_q != '0) && (y != prev_y_q)};
        last_vec = (k_q == num_vec_q - 1'b1);
    end

    // Control FSM with registered outputs and activity counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            mode_q      <= MODE_BIN;
            num_vec_q   <= '0;
            k_q         <= '0;
            vec_q       <= '0;
            prev_vec_q  <= '0;
            prev_y_q    <= 1'b0;
            in_tog_q    <= '0;
            out_tog_q   <= '0;
            ones_q      <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mode_q    <= mode_i;
                        num_vec_q <= num_vec_i;
                        k_q       <= '0;
                        in_tog_q  <= '0;
                        out_tog_q <= '0;
                        ones_q    <= '0;
                        busy_q    <= 1'b1;
                        if (num_vec_i == '0) begin
                            res_valid_q <= 1'b1;
                            state_q     <= StReport;
                        end else begin
                            vec_q   <= vec_first;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    ones_q     <= sat_add(ones_q, {2'b00, y});
                    in_tog_q   <= sat_add(in_tog_q, in_inc);
                    out_tog_q  <= sat_add(out_tog_q, out_inc);
                    prev_vec_q <= vec_q;
                    prev_y_q   <= y;
                    k_q        <= k_next;
                    if (last_vec) begin
                        res_valid_q <= 1'b1;
                        state_q     <= StReport;
                    end else begin
                        vec_q <= vec_next;
                    end
                end
                StReport: begin
                    if (res_ready_i) begin
                        done_q      <= 1'b1;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign vec_o         = vec_q;
    assign y_o           = y;
    assign res_valid_o   = res_valid_q;
    assign in_toggles_o  = in_tog_q;
    assign out_toggles_o = out_tog_q;
    assign ones_o        = ones_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_pwr_vec_sched.sv
// Self-checking bench for pwr_vec_sched: table vectors, hand sequences, random runs.
module tb_pwr_vec_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [3:0]  seed;
    logic [15:0] num_vec;
    logic        busy;
    logic [3:0]  vec;
    logic        y;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] in_toggles;
    logic [15:0] out_toggles;
    logic [15:0] ones;
    logic        done;

    // Narrow-counter instance for saturation.
    logic        start2;
    logic [1:0]  mode2;
    logic [3:0]  seed2;
    logic [3:0]  num_vec2;
    logic        busy2;
    logic [3:0]  vec2;
    logic        y2;
    logic        res_valid2;
    logic        res_ready2;
    logic [3:0]  in_toggles2;
    logic [3:0]  out_toggles2;
    logic [3:0]  ones2;
    logic        done2;

    int n_checks = 0;
    int n_errs   = 0;

    pwr_vec_sched #(.NUM_IN(4), .CNT_W(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .mode_i        (mode),
        .seed_i        (seed),
        .num_vec_i     (num_vec),
        .busy_o        (busy),
        .vec_o         (vec),
        .y_o           (y),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .in_toggles_o  (in_toggles),
        .out_toggles_o (out_toggles),
        .ones_o        (ones),
        .done_o        (done)
    );

    pwr_vec_sched #(.NUM_IN(4), .CNT_W(4)) dut_narrow (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start2),
        .mode_i        (mode2),
        .seed_i        (seed2),
        .num_vec_i     (num_vec2),
        .busy_o        (busy2),
        .vec_o         (vec2),
        .y_o           (y2),
        .res_valid_o   (res_valid2),
        .res_ready_i   (res_ready2),
        .in_toggles_o  (in_toggles2),
        .out_toggles_o (out_toggles2),
        .ones_o        (ones2),
        .done_o        (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: cut function straight from its equation.
    function automatic bit model_y(input logic [3:0] v);
        bit n1, n2, n3, n4;
        n1 = v[0]; n2 = v[1]; n3 = v[2]; n4 = v[3];
        return ((!n1) && n4) ^ (n2 && n3 && n4);
    endfunction

    // Reference: k-th vector of the selected order.
    function automatic logic [3:0] model_vec(input logic [1:0] m, input logic [3:0] s, input int k);
        int b;
        logic [3:0] v;
        b = k % 16;
        if (m == 2'd1) return 4'(b ^ (b >> 1));
        if (m == 2'd2) begin
            v = (s == 4'd0) ? 4'd1 : s;
            for (int i = 0; i < k % 15; i++) v = {v[2:0], v[3] ^ v[2]};
            return v;
        end
        return 4'(b);
    endfunction

    // Reference: totals over a whole run, saturated to the counter width at the end.
    task automatic model_counts(input logic [1:0] m, input logic [3:0] s, input int nv,
                                input int w, output int it, output int ot, output int on);
        logic [3:0] cur, prv;
        int lim;
        it = 0; ot = 0; on = 0;
        prv = 4'd0;
        for (int k = 0; k < nv; k++) begin
            cur = model_vec(m, s, k);
            on += int'(model_y(cur));
            if (k > 0) begin
                it += $countones(cur ^ prv);
                ot += int'(model_y(cur) != model_y(prv));
            end
            prv = cur;
        end
        lim = (1 << w) - 1;
        if (it > lim) it = lim;
        if (ot > lim) ot = lim;
        if (on > lim) on = lim;
    endtask

    // One complete run: start, follow the vector stream, hold REPORT for `delay`
    // cycles, accept, and check the done pulse. A second start is pulsed at k == poke_at.
    task automatic do_run(input string tag, input logic [1:0] m, input logic [3:0] s,
                          input int nv, input int delay, input int poke_at,
                          input int e_it, input int e_ot, input int e_on);
        int k;
        int seq_err;
        int hold_err;
        logic [15:0] it_s, ot_s, on_s;
        @(negedge clk);
        start = 1'b1; mode = m; seed = s; num_vec = 16'(nv); res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        seq_err = 0;
        while (!res_valid && k < nv + 5) begin
            if (busy !== 1'b1 || vec !== model_vec(m, s, k) || y !== model_y(vec)) seq_err++;
            if (k == poke_at) begin
                start = 1'b1; mode = 2'd1; num_vec = 16'd3; seed = 4'd7;
            end
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        check({tag, " run_len"}, k, nv);
        check({tag, " vec_seq_errs"}, seq_err, 0);
        check({tag, " res_valid"}, {31'd0, res_valid}, 1);
        check({tag, " in_toggles"}, {16'd0, in_toggles}, e_it);
        check({tag, " out_toggles"}, {16'd0, out_toggles}, e_ot);
        check({tag, " ones"}, {16'd0, ones}, e_on);
        it_s = in_toggles; ot_s = out_toggles; on_s = ones;
        hold_err = 0;
        for (int i = 0; i < delay; i++) begin
            if (res_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                in_toggles !== it_s || out_toggles !== ot_s || ones !== on_s) hold_err++;
            @(negedge clk);
        end
        check({tag, " report_hold_errs"}, hold_err, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, " done_pulse"}, {29'd0, done, busy, res_valid}, 32'b100);
        check({tag, " counters_kept"}, {in_toggles, out_toggles[7:0], ones[7:0]},
              {it_s, ot_s[7:0], on_s[7:0]});
        @(negedge clk);
        check({tag, " done_drop"}, {31'd0, done}, 0);
    endtask

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic [3:0] seed;
        int         nv;
        int         delay;
        int         e_it;
        int         e_ot;
        int         e_on;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int e_it, e_ot, e_on;
        int err, cyc;

        tbl[0] = '{"bin16",    2'd0, 4'd0, 16, 0, 26,  7, 4};
        tbl[1] = '{"gray16",   2'd1, 4'd0, 16, 0, 15,  7, 4};
        tbl[2] = '{"lfsr_s0",  2'd2, 4'd0, 15, 0, 30,  5, 4};
        tbl[3] = '{"lfsr_s1",  2'd2, 4'd1, 15, 0, 30,  5, 4};
        tbl[4] = '{"mode3",    2'd3, 4'd9, 16, 0, 26,  7, 4};
        tbl[5] = '{"bin1",     2'd0, 4'd0,  1, 0,  0,  0, 0};
        tbl[6] = '{"bin10",    2'd0, 4'd0, 10, 1, 16,  2, 1};
        tbl[7] = '{"bin32",    2'd0, 4'd0, 32, 0, 56, 15, 8};
        tbl[8] = '{"nv0_hold", 2'd0, 4'd0,  0, 5,  0,  0, 0};

        rst = 1'b0; start = 1'b0; mode = 2'd0; seed = 4'd0; num_vec = 16'd0; res_ready = 1'b0;
        start2 = 1'b0; mode2 = 2'd0; seed2 = 4'd0; num_vec2 = 4'd0; res_ready2 = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset busy/valid/done", {29'd0, busy, res_valid, done}, 0);
        check("reset vec", {28'd0, vec}, 0);
        check("reset counters", {in_toggles, out_toggles | ones}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_run(tbl[i].name, tbl[i].mode, tbl[i].seed, tbl[i].nv, tbl[i].delay, -1,
                   tbl[i].e_it, tbl[i].e_ot, tbl[i].e_on);
        end

        // LFSR from seed 0 never hits the all-zero vector and visits 15 distinct values.
        begin
            logic [15:0] seen;
            seen = 16'd0;
            @(negedge clk);
            start = 1'b1; mode = 2'd2; seed = 4'd0; num_vec = 16'd15; res_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 0;
            while (!res_valid && cyc < 30) begin
                seen[vec] = 1'b1;
                @(negedge clk);
                cyc++;
            end
            check("lfsr_distinct_nonzero", {16'd0, seen}, 32'hfffe);
            @(negedge clk);
            res_ready = 1'b0;
        end

        // Second start during RUN must be ignored.
        do_run("restart_ignored", 2'd0, 4'd0, 16, 0, 3, 26, 7, 4);

        // Reset mid-run at k=5.
        @(negedge clk);
        start = 1'b1; mode = 2'd0; num_vec = 16'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset vec", {28'd0, vec}, 5);
        check("pre_reset in_toggles", {16'd0, in_toggles}, 7);
        #1 rst = 1'b1;
        #1;
        check("midrun_reset flags", {29'd0, busy, res_valid, done}, 0);
        check("midrun_reset vec_y", {27'd0, vec, y}, 0);
        check("midrun_reset counters", {in_toggles, out_toggles | ones}, 0);
        @(negedge clk);
        rst = 1'b0;
        err = 0;
        for (int i = 0; i < 20; i++) begin
            if (done !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) err++;
            @(negedge clk);
        end
        check("post_reset_quiet", err, 0);

        // Randomised runs against the reference model.
        for (int r = 0; r < 25; r++) begin
            logic [1:0] rm;
            logic [3:0] rs;
            int rn, rd;
            rm = 2'($urandom_range(0, 3));
            rs = 4'($urandom_range(0, 15));
            rn = int'($urandom_range(0, 40));
            rd = int'($urandom_range(0, 3));
            model_counts(rm, rs, rn, 16, e_it, e_ot, e_on);
            do_run($sformatf("rand%0d", r), rm, rs, rn, rd, -1, e_it, e_ot, e_on);
        end

        // Saturation on the 4-bit counter build.
        @(negedge clk);
        start2 = 1'b1; mode2 = 2'd0; num_vec2 = 4'd15;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        while (!res_valid2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("narrow run_len", cyc, 15);
        check("narrow in_toggles sat", {28'd0, in_toggles2}, 15);
        check("narrow out_toggles", {28'd0, out_toggles2}, 6);
        check("narrow ones", {28'd0, ones2}, 3);
        res_ready2 = 1'b1;
        @(negedge clk);
        res_ready2 = 1'b0;
        check("narrow done", {30'd0, done2, busy2}, 2);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/pwr_vec_sched.md
Name: pwr_vec_sched

Overview:
- Sequences the 4-input power sub-circuit `power_cut_eval`, defined as y = (~n_1 & n_4) ^ (n_2 & n_3 & n_4).
- Applies one input vector per clock in binary, Gray or LFSR order, and measures switching activity: input bit toggles, output toggles, and output ones.
- Returns the totals over a valid/ready result handshake.
- Used by the rewrite power flow to compare activity before and after rewriting.

Parameters:
- NUM_IN, 4, input width of the evaluated cut. The vector order and the LFSR polynomial are defined for 4 only.
- CNT_W, 16, width of `num_vec` and of every result counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run. Sampled only in IDLE.
- mode  in  2  vector order: 0 binary, 1 Gray, 2 LFSR, 3 reserved (treated as binary).
- seed  in  4  LFSR seed. A seed of 0 is replaced by 4'b0001.
- num_vec  in  CNT_W  number of vectors to apply. Latched at start.
- busy  out  1  high in RUN and REPORT.
- vec  out  4  current vector. Bit mapping: vec[0]=n_1, vec[1]=n_2, vec[2]=n_3, vec[3]=n_4.
- y  out  1  combinational cut output for `vec`.
- res_valid  out  1  results are valid.
- res_ready  in  1  downstream accepts the results.
- in_toggles  out  CNT_W  sum of popcount(V(k) ^ V(k-1)).
- out_toggles  out  CNT_W  count of y(k) != y(k-1).
- ones  out  CNT_W  count of y(k) == 1.
- done  out  1  one-cycle pulse when the results are accepted.

Behaviour:
- Reset values: FSM=IDLE; vec, all counters, index, and prev_vec/prev_y = 0; busy, res_valid and done = 0.
- FSM states: IDLE, RUN, REPORT.
- IDLE:
  - On start, latch mode, num_vec and the seed, and clear all counters and k.
  - If num_vec == 0, go directly to REPORT, with all counters 0.
  - Otherwise, load vec = V(0) and go to RUN on the next cycle.
- Vector sequence V(k):
  - Binary: k mod 16.
  - Gray: b ^ (b >> 1), with b = k mod 16.
  - LFSR: Fibonacci x^4+x^3+1, V(0) = seed. Each step shifts left and sets lsb = v[3] ^ v[2]. Period 15.
- RUN, each cycle with vec = V(k):
  - ones += y.
  - If k > 0: in_toggles += popcount(vec ^ prev_vec), and out_toggles += (y != prev_y).
  - Then prev_vec <= vec, prev_y <= y, k <= k+1.
  - If k == num_vec-1, go to REPORT; otherwise vec <= V(k+1).
  - Throughput is 1 vector per clock. A run lasts num_vec cycles in RUN.
- Counter width: all counters saturate at 2^CNT_W-1 and never wrap.
- REPORT:
  - res_valid = 1 and the counters are held stable.
  - On res_valid & res_ready: assert done for one cycle, return to IDLE, and drop res_valid. Counters keep their values until the next start.
- start while busy is ignored.
- Asserting rst mid-run aborts immediately to the reset values. No result and no done are produced.
- In IDLE and after a run, vec holds its last value. y always reflects vec.

Decomposition:
- Package `pwr_sched_pkg`:
  - state enum {IDLE, RUN, REPORT}.
  - mode constants MODE_BIN=0, MODE_GRAY=1, MODE_LFSR=2.
  - LFSR tap constant and the default seed 4'b0001.
- Sub-module `power_cut_eval`: purely combinational 4-in/1-out cut, instantiated once on vec. This lets it be swapped for rewritten variants of the cut.

Test Plan:
- Binary, num_vec=16, res_ready=1 -> y over k=0..15 is 0,0,0,0,0,0,0,0,1,0,1,0,1,0,0,1. Expect in_toggles=26, out_toggles=7, ones=4. busy lasts 17 cycles, then a single done pulse.
- Gray, num_vec=16 -> vec sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8. Expect in_toggles=15, out_toggles=7, ones=4.
- LFSR, seed=0 (substituted by 1), num_vec=15 -> 15 distinct nonzero vectors, vec never 0. ones=4 (vectors 8,10,12,15). Rerunning with seed=1 gives identical counters.
- num_vec=0 -> REPORT on the cycle after start, all counters 0. Hold res_ready=0 for 5 cycles -> res_valid and the counters stay stable, done stays low. Then res_ready=1 -> one done pulse.
- Binary, CNT_W=4 build, num_vec=15 (binary order wraps after 16 vectors) -> in_toggles saturates at 15 and does not wrap.
- Assert rst during RUN at k=5 -> all outputs return to reset values asynchronously with no done. A second start pulse during RUN is ignored, and the run result matches an undisturbed run.
